// File: rtl/hanoi_move_gen.sv
// Purpose     : emits the optimal 2^S-1 Tower-of-Hanoi move sequence (peg 0 -> peg 2) as fr/to moves.
// Latency     : first move is valid one cycle after start; done pulses two cycles after the last accepted move.
// Backpressure: valid/ready; fr/to/mv_valid are registered and hold while mv_valid & !mv_ready.
//
// Ports: clk, rst_n (async active-low), start (sampled in IDLE), busy (RUN),
//        done (1-cycle pulse), mv_valid/mv_ready (move handshake), fr/to (peg codes 0..2),
//        mv_cnt (moves accepted this/last sequence), err (sticky illegal-move flag).
// Optional feature: define HANOI_MOVE_CHECK_EN to build the shadow peg-occupancy
// checker that drives err; otherwise err is tied to 0.
module hanoi_move_gen #(
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [1:0]   fr,
  output logic [1:0]   to,
  output logic [S-1:0] mv_cnt,
  output logic         err
);

  localparam logic [S-1:0] K_LAST = {S{1'b1}};
  localparam bit           S_EVEN = (S % 2) == 0;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t       state_q, state_d;
  logic [S-1:0] k_q, k_d;
  logic [S-1:0] mv_cnt_q, mv_cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         mv_valid_q, mv_valid_d;
  logic [1:0]   fr_q, fr_d;
  logic [1:0]   to_q, to_d;

  logic [S-1:0] k_nxt;
  logic [3:0]   mv_nxt;
  logic         hs;

  function automatic logic [1:0] mod3(input logic [S:0] x);
    return 2'(x % (S+1)'(3));
  endfunction

  // Even stack heights mirror the odd-height sequence with pegs 1 and 2 exchanged.
  function automatic logic [1:0] swap12(input logic [1:0] c);
    case (c)
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return c;
    endcase
  endfunction

  // Move k: source = (k & (k-1)) mod 3, dest = ((k | (k-1)) + 1) mod 3.
  // Widened to S+1 bits because (k | (k-1)) + 1 reaches 2^S on the last move.
  function automatic logic [3:0] move_of(input logic [S-1:0] k);
    logic [S:0] kx;
    logic [S:0] km1;
    logic [1:0] f;
    logic [1:0] d;
    kx  = {1'b0, k};
    km1 = kx - 1'b1;
    f   = mod3(kx & km1);
    d   = mod3((kx | km1) + 1'b1);
    if (S_EVEN) begin
      f = swap12(f);
      d = swap12(d);
    end
    return {f, d};
  endfunction

  assign hs     = (state_q == RUN) & mv_valid_q & mv_ready;
  // In IDLE the next move to load is move 1; in RUN it is k+1.
  assign k_nxt  = (state_q == RUN) ? k_q + 1'b1 : {{(S-1){1'b0}}, 1'b1};
  assign mv_nxt = move_of(k_nxt);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mv_cnt_d   = mv_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mv_valid_d = mv_valid_q;
    fr_d       = fr_q;
    to_d       = to_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          k_d        = k_nxt;
          mv_cnt_d   = '0;
          busy_d     = 1'b1;
          mv_valid_d = 1'b1;
          fr_d       = mv_nxt[3:2];
          to_d       = mv_nxt[1:0];
        end
      end
      RUN: begin
        if (hs) begin
          mv_cnt_d = mv_cnt_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d    = FIN;
            busy_d     = 1'b0;
            mv_valid_d = 1'b0;
          end else begin
            k_d  = k_nxt;
            fr_d = mv_nxt[3:2];
            to_d = mv_nxt[1:0];
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      mv_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mv_valid_q <= 1'b0;
      fr_q       <= 2'b00;
      to_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mv_cnt_q   <= mv_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mv_valid_q <= mv_valid_d;
      fr_q       <= fr_d;
      to_q       <= to_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mv_valid = mv_valid_q;
  assign fr       = fr_q;
  assign to       = to_q;
  assign mv_cnt   = mv_cnt_q;

`ifdef HANOI_MOVE_CHECK_EN
  // Shadow occupancy: bit i of mask[p] = disk i on peg p (bit 0 smallest).
  // Entry 3 exists only so a 2-bit peg code always indexes in range; it stays 0.
  logic [S-1:0] mask_q [4];
  logic [S-1:0] mask_d [4];
  logic         err_q, err_d;
  logic [S-1:0] src, dst, src_lsb, dst_lsb;
  logic         legal;

  always_comb begin
    src     = mask_q[fr_q];
    dst     = mask_q[to_q];
    src_lsb = src & (~src + 1'b1);
    dst_lsb = dst & (~dst + 1'b1);
    legal   = (src != '0) && ((dst == '0) || (dst_lsb > src_lsb));
    mask_d  = mask_q;
    err_d   = err_q;
    if ((state_q == IDLE) && start) begin
      mask_d[0] = {S{1'b1}};
      mask_d[1] = '0;
      mask_d[2] = '0;
      mask_d[3] = '0;
      err_d     = 1'b0;
    end else if (hs) begin
      // Clear first, then set, so a degenerate fr==to move leaves the mask intact.
      mask_d[fr_q] = mask_q[fr_q] & ~src_lsb;
      mask_d[to_q] = mask_d[to_q] | src_lsb;
      if (!legal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q[0] <= {S{1'b1}};
      mask_q[1] <= '0;
      mask_q[2] <= '0;
      mask_q[3] <= '0;
      err_q     <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
